// File: rtl/sprite_line_renderer_if.sv
// Sprite bitmap ROM bus.
// The renderer (master) drives a row address. The ROM (slave) returns that
// row's bits on rom_data one clock later, as a synchronous read.
// There is no valid/ready handshake: the fixed one-cycle read latency is the
// whole contract, and the renderer samples rom_data exactly one cycle after
// presenting rom_addr.
//   rom_addr  master->slave  $clog2(HEIGHT)  bitmap row address
//   rom_data  slave->master  WIDTH           row bits, bit WIDTH-1 = leftmost
interface sprite_line_renderer_if #(
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 16
) ();
  logic [$clog2(HEIGHT)-1:0] rom_addr;
  logic [WIDTH-1:0]          rom_data;

  modport master (output rom_addr, input rom_data);
  modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/sprite_line_renderer.sv
// Single-sprite line renderer.
// A rising edge on hsync causes one bitmap row to be fetched into a line
// buffer. That row is the one the *next* scanline needs. When the beam then
// reaches sprite_x, the row is shifted out as a pixel mask. The renderer
// supports horizontal flip, vertical flip and 2x scaling.
// Ports:
//   clk, reset          pixel clock, synchronous active-high reset
//   hpos, vpos          beam position
//   hsync               horizontal sync (rising edge starts a line fetch)
//   sprite_x, sprite_y  sprite top-left corner in beam coordinates
//   hflip, vflip        mirror columns / rows
//   scale2              1 = each pixel and row is drawn twice
//   rom                 bitmap ROM bus (master side)
//   gfx                 registered: sprite pixel is opaque
//   active              registered: draw window is open
//   dbg_state           current FSM state (IDLE=0 FETCH=1 LOAD=2 WAIT_X=3 DRAW=4)
module sprite_line_renderer #(
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 16,
  parameter int POSW   = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [POSW-1:0]       hpos,
  input  logic [POSW-1:0]       vpos,
  input  logic                  hsync,
  input  logic [POSW-1:0]       sprite_x,
  input  logic [POSW-1:0]       sprite_y,
  input  logic                  hflip,
  input  logic                  vflip,
  input  logic                  scale2,
  sprite_line_renderer_if.master rom,
  output logic                  gfx,
  output logic                  active,
  output logic [2:0]            dbg_state
);
  localparam int AW = $clog2(HEIGHT);
  localparam int XW = $clog2(WIDTH);
  localparam int CW = XW + 1;

  localparam logic [POSW:0]   LIM1     = (POSW+1)'(HEIGHT);
  localparam logic [POSW:0]   LIM2     = (POSW+1)'(2 * HEIGHT);
  localparam logic [CW-1:0]   SPAN1    = CW'(WIDTH - 1);
  localparam logic [CW-1:0]   SPAN2    = CW'(2 * WIDTH - 1);
  localparam logic [XW-1:0]   PTR_TOP  = XW'(WIDTH - 1);
  localparam logic [XW-1:0]   PTR_NEXT = XW'(WIDTH - 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_WAIT_X = 3'd3,
    S_DRAW   = 3'd4
  } state_t;

  state_t state, next_state;

  logic             hsync_q;
  logic             hs_rise;
  logic [POSW-1:0]  dy;
  logic             in_range;
  logic [AW-1:0]    row_sel;
  logic [POSW-1:0]  x_q;
  logic             hflip_q;
  logic             scale_q;
  logic [WIDTH-1:0] line_buf;
  logic [WIDTH-1:0] rom_rev;
  logic [CW-1:0]    cnt;
  logic [XW-1:0]    ptr;
  logic             half;
  logic             x_hit;
  logic             gfx_d;
  logic             active_d;

  assign hs_rise   = hsync & ~hsync_q;
  assign x_hit     = (hpos == x_q);
  assign dbg_state = state;

  // Vertical selection targets the scanline after the one in progress.
  // dy wraps modulo 2^POSW, so a sprite straddling line 0 still matches.
  always_comb begin
    dy       = vpos + POSW'(1) - sprite_y;
    in_range = ({1'b0, dy} < (scale2 ? LIM2 : LIM1));
    row_sel  = AW'(scale2 ? (dy >> 1) : dy);
    // HEIGHT is a power of two, so HEIGHT-1-row is just the bit inverse.
    if (vflip) row_sel = ~row_sel;
  end

  always_comb begin
    for (int i = 0; i < WIDTH; i++) rom_rev[i] = rom.rom_data[WIDTH-1-i];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next state plus the pixel that will be registered onto gfx/active.
  // The first pixel is emitted from the WAIT_X match cycle. This gives
  // column k at hpos == sprite_x + k + 1.
  always_comb begin
    next_state = state;
    gfx_d      = 1'b0;
    active_d   = 1'b0;
    if (hs_rise) begin
      next_state = in_range ? S_FETCH : S_IDLE;
    end else begin
      case (state)
        S_FETCH:  next_state = S_LOAD;
        S_LOAD:   next_state = S_WAIT_X;
        S_WAIT_X: begin
          if (x_hit) begin
            next_state = S_DRAW;
            gfx_d      = line_buf[WIDTH-1];
            active_d   = 1'b1;
          end
        end
        S_DRAW: begin
          if (cnt == '0) begin
            next_state = S_IDLE;
          end else begin
            gfx_d    = line_buf[ptr];
            active_d = 1'b1;
          end
        end
        default: next_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hsync_q      <= 1'b0;
      x_q          <= '0;
      hflip_q      <= 1'b0;
      scale_q      <= 1'b0;
      rom.rom_addr <= '0;
      line_buf     <= '0;
      cnt          <= '0;
      ptr          <= '0;
      half         <= 1'b0;
      gfx          <= 1'b0;
      active       <= 1'b0;
    end else begin
      hsync_q <= hsync;
      gfx     <= gfx_d;
      active  <= active_d;
      if (hs_rise) begin
        x_q     <= sprite_x;
        hflip_q <= hflip;
        scale_q <= scale2;
        if (in_range) rom.rom_addr <= row_sel;
        else          line_buf     <= '0;
      end else begin
        case (state)
          S_LOAD: line_buf <= hflip_q ? rom_rev : rom.rom_data;
          S_WAIT_X: begin
            if (x_hit) begin
              // Column 0 goes out this cycle. ptr names the buffer bit for
              // the next DRAW cycle, which at 2x is column 0 again.
              cnt  <= scale_q ? SPAN2 : SPAN1;
              ptr  <= scale_q ? PTR_TOP : PTR_NEXT;
              half <= 1'b1;
            end
          end
          S_DRAW: begin
            if (cnt != '0) begin
              cnt <= cnt - CW'(1);
              if (!scale_q || half) ptr <= ptr - XW'(1);
              half <= ~half;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sprite_line_renderer.sv
// Bench for sprite_line_renderer.
// Lines of 128 columns are driven, with hsync high for 8 columns.
// A model computes the expected pixels of the coming line from the sprite
// rules at each hsync rise. It queues them as {hpos, gfx}. A monitor then
// pops the queue on every cycle in which active is high.
module tb_sprite_line_renderer;
  localparam int WIDTH   = 16;
  localparam int HEIGHT  = 16;
  localparam int POSW    = 9;
  localparam int H_TOTAL = 128;

  logic             clk = 1'b0;
  logic             reset;
  logic [POSW-1:0]  hpos, vpos, sprite_x, sprite_y;
  logic             hsync, hflip, vflip, scale2;
  logic             gfx, active;
  logic [2:0]       dbg_state;

  sprite_line_renderer_if #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) rom_bus ();

  sprite_line_renderer #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .POSW(POSW)) dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .hsync(hsync),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .hflip(hflip), .vflip(vflip),
    .scale2(scale2), .rom(rom_bus), .gfx(gfx), .active(active),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] rom_mem [HEIGHT];
  always @(posedge clk) rom_bus.rom_data <= rom_mem[rom_bus.rom_addr];

  logic [15:0]        exp_q[$];
  int                 total_cnt = 0;
  int                 pass_cnt  = 0;
  int                 act_cnt, act_first, fetch_cnt, fetch_addr;
  logic [H_TOTAL-1:0] gfx_mask;
  logic               mon_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_mask(input string name, input logic [H_TOTAL-1:0] act,
                            input logic [H_TOTAL-1:0] exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [H_TOTAL-1:0] span_mask(input int lo, input int hi);
    logic [H_TOTAL-1:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Monitor: line statistics + scoreboard pop on every active cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (dbg_state == 3'd1) begin
        fetch_cnt++;
        fetch_addr = int'(rom_bus.rom_addr);
      end
      if (active) begin
        logic [15:0] got, e;
        act_cnt++;
        if (act_first < 0) act_first = int'(hpos);
        if (gfx && hpos < 9'(H_TOTAL)) gfx_mask[hpos[6:0]] = 1'b1;
        got = {6'd0, hpos, gfx};
        total_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL pixel_unexpected: hpos %0d gfx %0d, expected no pixel", hpos, gfx);
        end else begin
          e = exp_q.pop_front();
          if (got == e) pass_cnt++;
          else $display("FAIL pixel: got hpos %0d gfx %0d, expected hpos %0d gfx %0d",
                        got[15:1], got[0], e[15:1], e[0]);
        end
      end
    end
  end

  // Reference: the hsync rise in cycle h_rise truncates anything still
  // pending, then describes the next scanline from the sprite rules.
  task automatic model_hs(input int v, input int h_rise);
    logic [15:0]      kept[$];
    logic [WIDTH-1:0] bits;
    int               dy, row, col, s;
    logic             pix;
    foreach (exp_q[i]) if (int'(exp_q[i][15:1]) <= h_rise) kept.push_back(exp_q[i]);
    exp_q = kept;
    check("line_drained", exp_q.size(), 0);
    s  = int'(scale2);
    dy = ((v + 1 - int'(sprite_y)) % (1 << POSW) + (1 << POSW)) % (1 << POSW);
    if (dy < (HEIGHT << s)) begin
      row = dy >> s;
      if (vflip) row = HEIGHT - 1 - row;
      bits = rom_mem[row];
      for (int k = 0; k < (WIDTH << s); k++) begin
        col = k >> s;
        pix = hflip ? bits[col] : bits[WIDTH-1-col];
        exp_q.push_back({15'(int'(sprite_x) + k + 1), pix});
      end
    end
  endtask

  task automatic run_line(input int v, input int hs_start, input int rst_at, input bit rnd);
    for (int h = 0; h < H_TOTAL; h++) begin
      @(posedge clk); #1;
      if (h == 0) begin
        act_cnt = 0; act_first = -1; fetch_cnt = 0; fetch_addr = -1; gfx_mask = '0;
      end
      hpos  = 9'(h);
      vpos  = 9'(v % (1 << POSW));
      hsync = (h >= hs_start) && (h < hs_start + 8);
      reset = (rst_at >= 0) && (h == rst_at);
      if (rst_at >= 0 && h == rst_at + 1) begin
        exp_q.delete();
        check("rst_gfx", int'(gfx), 0);
        check("rst_active", int'(active), 0);
        check("rst_rom_addr", int'(rom_bus.rom_addr), 0);
        check("rst_state", int'(dbg_state), 0);
      end
      if (rnd && h == 20) begin
        sprite_x = 9'($urandom_range(0, 70));
        hflip    = 1'($urandom_range(0, 1));
        vflip    = 1'($urandom_range(0, 1));
        scale2   = 1'($urandom_range(0, 1));
      end
      if (h == hs_start + 1) model_hs(v, hs_start);
    end
  endtask

  task automatic clear_rom();
    for (int r = 0; r < HEIGHT; r++) rom_mem[r] = '0;
  endtask

  initial begin
    reset = 1'b1; hsync = 1'b0; hpos = '0; vpos = '0;
    sprite_x = 9'd50; sprite_y = 9'd100; hflip = 1'b0; vflip = 1'b0; scale2 = 1'b0;
    clear_rom();
    repeat (3) @(posedge clk);
    #1;
    check("reset_gfx", int'(gfx), 0);
    check("reset_active", int'(active), 0);
    check("reset_rom_addr", int'(rom_bus.rom_addr), 0);
    check("reset_state", int'(dbg_state), 0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // 1x, no flip, row 0 = 8001
    rom_mem[0] = 16'h8001;
    run_line(99, 110, -1, 0);
    check("plain_fetch_cnt", fetch_cnt, 1);
    check("plain_fetch_addr", fetch_addr, 0);
    run_line(100, 110, -1, 0);
    check_mask("plain_gfx", gfx_mask, span_mask(51, 51) | span_mask(66, 66));
    check("plain_active_cnt", act_cnt, 16);
    check("plain_active_first", act_first, 51);

    // hflip, row 0 = F000
    rom_mem[0] = 16'hF000; hflip = 1'b1;
    run_line(99, 110, -1, 0);
    run_line(100, 110, -1, 0);
    check_mask("hflip_gfx", gfx_mask, span_mask(63, 66));
    hflip = 1'b0; vflip = 1'b1;
    run_line(99, 110, -1, 0);
    check("vflip_fetch_addr", fetch_addr, 15);
    vflip = 1'b0;

    // 2x, row 0 = 8000
    rom_mem[0] = 16'h8000; scale2 = 1'b1;
    run_line(99, 110, -1, 0);
    check("x2_fetch_line100", fetch_addr, 0);
    run_line(100, 110, -1, 0);
    check_mask("x2_gfx", gfx_mask, span_mask(51, 52));
    check("x2_active_cnt", act_cnt, 32);
    check("x2_fetch_line101", fetch_addr, 0);
    run_line(130, 110, -1, 0);
    check("x2_fetch_line131", fetch_addr, 15);
    run_line(131, 110, -1, 0);
    check("x2_no_fetch_line132", fetch_cnt, 0);
    scale2 = 1'b0;

    // vertical wrap
    sprite_y = 9'd510;
    run_line(510, 110, -1, 0);
    check("wrap_fetch_line511", fetch_addr, 1);
    run_line(511, 110, -1, 0);
    check("wrap_fetch_line0", fetch_addr, 2);

    // sprite_x beyond the visible line
    sprite_y = 9'd100; sprite_x = 9'd500;
    run_line(99, 110, -1, 0);
    run_line(100, 110, -1, 0);
    check("abort_active_cnt", act_cnt, 0);
    check_mask("abort_gfx", gfx_mask, '0);
    check("abort_refetch", fetch_cnt, 1);

    // hsync rise in the middle of a draw
    sprite_x = 9'd50; rom_mem[0] = 16'hFFFF;
    run_line(99, 110, -1, 0);
    run_line(100, 58, -1, 0);
    check("middraw_active_cnt", act_cnt, 8);
    check_mask("middraw_gfx", gfx_mask, span_mask(51, 58));
    run_line(101, 110, -1, 0);

    // reset in the middle of a draw
    run_line(99, 110, -1, 0);
    run_line(100, 110, 55, 0);
    check("rstdraw_active_cnt", act_cnt, 5);
    run_line(101, 110, -1, 0);

    // randomized blocks of consecutive lines
    for (int b = 0; b < 8; b++) begin
      int v0, off;
      v0  = int'($urandom_range(0, 511));
      off = int'($urandom_range(0, 30));
      for (int r = 0; r < HEIGHT; r++) rom_mem[r] = 16'($urandom);
      sprite_y = 9'((v0 + 1 - off) & 511);
      for (int i = 0; i < 6; i++) run_line((v0 + i) % 512, 110, -1, 1);
    end

    // one out-of-range line to flush the last randomized row
    sprite_y = 9'd0;
    run_line(300, 110, -1, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
